mapu_row_packer: RTL and testbench

- Upstream feeder for the Matrix APU block.
- Takes a serial element stream (one DATA_W element per beat, row-major, 16 elements per 4x4 matrix) and packs it into four row buses plus an opcode.
- Presents the packed matrix to the APU input with a valid/ready handshake.
- Two-slot ping-pong buffer: the next matrix fills while the previous one waits for the APU.

---
 rtl/mapu_pkg.sv | 20 ++
 rtl/mapu_row_packer_if.sv | 34 +++
 rtl/mapu_row_packer_slot.sv | 55 +++++
 rtl/mapu_row_packer.sv | 183 ++++++++++++++++++
 tb/tb_mapu_row_packer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mapu_pkg.sv
// Shared constants and types for the Matrix APU row packer.
package mapu_pkg;

  localparam int unsigned MAPU_DIM    = 4;
  localparam int unsigned MAPU_ELEMS  = 16;
  localparam int unsigned MAPU_IDX_W  = $clog2(MAPU_ELEMS);
  localparam int unsigned MAPU_DATA_W = 8;
  localparam int unsigned MAPU_OP_W   = 2;
  localparam int unsigned MAPU_ROW_W  = MAPU_DIM * MAPU_DATA_W;

  typedef logic [MAPU_OP_W-1:0]  mapu_op_t;
  typedef logic [MAPU_ROW_W-1:0] mapu_row_t;

  // Packer framing state: FILL writes elements, DROP discards the tail of an over-long frame.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_DROP = 1'b1
  } pk_state_e;

endpackage

// File: rtl/mapu_row_packer_if.sv
// Element stream in / packed matrix out bundle for the row packer.
interface mapu_row_packer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 2
);
  localparam int unsigned ROW_W = 4 * DATA_W;

  logic              s_vld;
  logic              s_rdy;
  logic [DATA_W-1:0] s_data;
  logic [OP_W-1:0]   s_op;
  logic              s_last;

  logic              o_vld;
  logic              o_rdy;
  logic [OP_W-1:0]   o_op;
  logic [ROW_W-1:0]  o_r0;
  logic [ROW_W-1:0]  o_r1;
  logic [ROW_W-1:0]  o_r2;
  logic [ROW_W-1:0]  o_r3;

  // Environment side: produces elements, consumes matrices.
  modport master (
    output s_vld, s_data, s_op, s_last, o_rdy,
    input  s_rdy, o_vld, o_op, o_r0, o_r1, o_r2, o_r3
  );

  // Packer side.
  modport slave (
    input  s_vld, s_data, s_op, s_last, o_rdy,
    output s_rdy, o_vld, o_op, o_r0, o_r1, o_r2, o_r3
  );

endinterface

// File: rtl/mapu_row_packer_slot.sv
// One matrix slot: four packed rows plus opcode, element-addressed write and clear.
module mapu_row_packer_slot
  import mapu_pkg::*;
#(
  parameter int unsigned DATA_W = MAPU_DATA_W,
  parameter int unsigned OP_W   = MAPU_OP_W
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 i_clr,
  input  logic                                 i_we,
  input  logic [MAPU_IDX_W-1:0]                i_idx,
  input  logic [DATA_W-1:0]                    i_data,
  input  logic [OP_W-1:0]                      i_op,
  output logic [MAPU_DIM-1:0][4*DATA_W-1:0]    o_rows,
  output logic [OP_W-1:0]                      o_op
);

  localparam int unsigned ROW_W = 4 * DATA_W;

  logic [MAPU_DIM-1:0][ROW_W-1:0] rows_q, rows_d;
  logic [OP_W-1:0]                op_q, op_d;
  logic [1:0]                     row_sel;
  logic [1:0]                     lane_sel;

  assign row_sel  = i_idx[MAPU_IDX_W-1:2];
  assign lane_sel = i_idx[1:0];

  // Clear wins over write; opcode travels with element 0.
  always_comb begin
    rows_d = rows_q;
    op_d   = op_q;
    if (i_clr) begin
      rows_d = '0;
      op_d   = '0;
    end else if (i_we) begin
      rows_d[row_sel][32'(lane_sel) * DATA_W +: DATA_W] = i_data;
      if (i_idx == '0) op_d = i_op;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_q <= '0;
      op_q   <= '0;
    end else begin
      rows_q <= rows_d;
      op_q   <= op_d;
    end
  end

  assign o_rows = rows_q;
  assign o_op   = op_q;

endmodule

// File: rtl/mapu_row_packer.sv
// Serial element stream to 4x4 row-packed matrix, two-slot ping-pong toward the APU.
// Optional MAPU_ROW_PACKER_STATS_EN adds saturating matrix/error counters.
module mapu_row_packer
  import mapu_pkg::*;
#(
  parameter int unsigned DATA_W = MAPU_DATA_W,
  parameter int unsigned OP_W   = MAPU_OP_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_en,
  input  logic               i_flush,
  mapu_row_packer_if.slave   bus,
  output logic               o_err
`ifdef MAPU_ROW_PACKER_STATS_EN
  ,
  output logic [15:0]        o_mat_cnt,
  output logic [15:0]        o_err_cnt
`endif
);

  localparam int unsigned ROW_W = MAPU_DIM * DATA_W;
  localparam logic [MAPU_IDX_W-1:0] IDX_LAST = MAPU_IDX_W'(MAPU_ELEMS - 1);

  logic                  rdy_ok_q;
  pk_state_e             state_q, state_d;
  logic [MAPU_IDX_W-1:0] idx_q, idx_d;
  logic [1:0]            count_q, count_d;
  logic                  wr_sel_q, wr_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic                  err_q, err_d;

  logic       s_rdy_c;
  logic       o_vld_c;
  logic       accept;
  logic       pop;
  logic       fill_acc;
  logic       at_last;
  logic       complete;
  logic [1:0] slot_we;

  logic [MAPU_DIM-1:0][ROW_W-1:0] slot_rows [2];
  logic [OP_W-1:0]                slot_op   [2];

  // Handshake terms depend on registers and current control inputs only.
  always_comb begin
    s_rdy_c  = rdy_ok_q & i_en & ~i_flush &
               ((state_q == ST_DROP) | (count_q < 2'd2));
    o_vld_c  = (count_q != 2'd0);
    accept   = bus.s_vld & s_rdy_c;
    pop      = o_vld_c & bus.o_rdy;
    fill_acc = accept & (state_q == ST_FILL);
    at_last  = (idx_q == IDX_LAST);
    complete = fill_acc & bus.s_last & at_last;
    slot_we  = '0;
    if (fill_acc) slot_we[wr_sel_q] = 1'b1;
  end

  // Framing, pointer and occupancy update; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    err_d    = 1'b0;
    if (i_flush) begin
      state_d  = ST_FILL;
      idx_d    = '0;
      count_d  = '0;
      wr_sel_d = 1'b0;
      rd_sel_d = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            if (bus.s_last && at_last) begin
              idx_d    = '0;
              wr_sel_d = ~wr_sel_q;
            end else if (bus.s_last) begin
              idx_d = '0;
              err_d = 1'b1;
            end else if (at_last) begin
              idx_d   = '0;
              err_d   = 1'b1;
              state_d = ST_DROP;
            end else begin
              idx_d = idx_q + MAPU_IDX_W'(1);
            end
          end
        end
        ST_DROP: begin
          if (accept && bus.s_last) state_d = ST_FILL;
        end
        default: state_d = ST_FILL;
      endcase
      if (pop) rd_sel_d = ~rd_sel_q;
      case ({complete, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_ok_q <= 1'b0;
      state_q  <= ST_FILL;
      idx_q    <= '0;
      count_q  <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdy_ok_q <= 1'b1;
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      err_q    <= err_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_slot
    mapu_row_packer_slot #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
    ) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (i_flush),
      .i_we    (slot_we[g]),
      .i_idx   (idx_q),
      .i_data  (bus.s_data),
      .i_op    (bus.s_op),
      .o_rows  (slot_rows[g]),
      .o_op    (slot_op[g])
    );
  end

  assign bus.s_rdy = s_rdy_c;
  assign bus.o_vld = o_vld_c;
  assign bus.o_op  = slot_op[rd_sel_q];
  assign bus.o_r0  = slot_rows[rd_sel_q][0];
  assign bus.o_r1  = slot_rows[rd_sel_q][1];
  assign bus.o_r2  = slot_rows[rd_sel_q][2];
  assign bus.o_r3  = slot_rows[rd_sel_q][3];
  assign o_err     = err_q;

`ifdef MAPU_ROW_PACKER_STATS_EN
  logic [15:0] mat_cnt_q, mat_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating counters, counted on the same edge that raises o_err / completes a pop.
  always_comb begin
    mat_cnt_d = mat_cnt_q;
    err_cnt_d = err_cnt_q;
    if (i_flush) begin
      mat_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (pop && (mat_cnt_q != 16'hFFFF)) mat_cnt_d = mat_cnt_q + 16'd1;
      if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mat_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      mat_cnt_q <= mat_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_mat_cnt = mat_cnt_q;
  assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mapu_row_packer.sv
// Self-checking bench for mapu_row_packer: directed scenarios plus randomized frames vs. a frame-level model.
module tb_mapu_row_packer;

  logic clk = 1'b0;
  logic reset_n;
  logic i_en;
  logic i_flush;
  logic o_err;
`ifdef MAPU_ROW_PACKER_STATS_EN
  logic [15:0] o_mat_cnt;
  logic [15:0] o_err_cnt;
`endif

  mapu_row_packer_if #(.DATA_W(8), .OP_W(2)) bus ();

  mapu_row_packer #(.DATA_W(8), .OP_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (i_en),
    .i_flush   (i_flush),
    .bus       (bus),
    .o_err     (o_err)
`ifdef MAPU_ROW_PACKER_STATS_EN
    ,
    .o_mat_cnt (o_mat_cnt),
    .o_err_cnt (o_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       op;
    logic [3:0][31:0] r;
  } mat_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Frame-level reference model state.
  mat_t       q[$];
  logic [7:0] cur[$];
  logic [1:0] cur_op;
  bit         dropping;
  int unsigned mat_exp;
  int unsigned errc_exp;

  bit rand_rdy;
  bit rand_en;
  bit gaps;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    cur.delete();
    dropping = 1'b0;
    mat_exp  = 0;
    errc_exp = 0;
  endtask

  task automatic model_accept(input logic [7:0] d, input logic [1:0] op, input logic last,
                              output logic err);
    mat_t m;
    err = 1'b0;
    if (dropping) begin
      if (last) dropping = 1'b0;
    end else begin
      if (cur.size() == 0) cur_op = op;
      cur.push_back(d);
      if (last || cur.size() == 16) begin
        if (last && cur.size() == 16) begin
          m.op = cur_op;
          m.r  = '0;
          for (int e = 0; e < 16; e++) m.r[e/4][(e%4)*8 +: 8] = cur[e];
          q.push_back(m);
        end else begin
          err = 1'b1;
          if (!last) dropping = 1'b1;
        end
        cur.delete();
      end
    end
  endtask

  // One clock: entered just after a negedge with inputs settled, leaves at the next negedge.
  task automatic tick(output logic acc);
    logic pop;
    logic err_exp;
    if (rand_rdy) bus.o_rdy = 1'($urandom_range(0, 1));
    if (rand_en)  i_en = ($urandom_range(0, 5) != 0);
    #1;
    if (!i_en) chk("s_rdy_when_disabled", bus.s_rdy, 1'b0);
    acc     = bus.s_vld & bus.s_rdy;
    pop     = bus.o_vld & bus.o_rdy;
    err_exp = 1'b0;
    if (i_flush) begin
      model_clear();
    end else begin
      if (pop) begin
        chk("pop_has_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          chk("pop_data", {bus.o_op, bus.o_r3, bus.o_r2, bus.o_r1, bus.o_r0}, q[0]);
          void'(q.pop_front());
          if (mat_exp != 16'hFFFF) mat_exp++;
        end
      end
      if (acc) model_accept(bus.s_data, bus.s_op, bus.s_last, err_exp);
      if (err_exp && errc_exp != 16'hFFFF) errc_exp++;
    end
    @(posedge clk);
    #1;
    chk("o_err", o_err, err_exp);
    chk("o_vld", bus.o_vld, q.size() != 0);
`ifdef MAPU_ROW_PACKER_STATS_EN
    chk("o_mat_cnt", o_mat_cnt, 16'(mat_exp));
    chk("o_err_cnt", o_err_cnt, 16'(errc_exp));
`endif
    @(negedge clk);
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic [1:0] op, input logic last);
    logic acc;
    int   n;
    if (gaps) begin
      bus.s_vld = 1'b0;
      repeat ($urandom_range(0, 2)) tick(acc);
    end
    bus.s_vld  = 1'b1;
    bus.s_data = d;
    bus.s_op   = op;
    bus.s_last = last;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 300) begin
      tick(acc);
      n++;
    end
    chk("beat_accepted", acc, 1'b1);
    bus.s_vld  = 1'b0;
    bus.s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [1:0] op, input int len);
    for (int i = 0; i < len; i++) drive_beat(8'(base + 8'(i)), op, i == len - 1);
  endtask

  task automatic send_random_frame(input int len);
    logic [1:0] op;
    op = 2'($urandom_range(0, 3));
    for (int i = 0; i < len; i++) drive_beat(8'($urandom_range(0, 255)), op, i == len - 1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    bus.o_rdy = 1'b1;
    bus.s_vld = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick(acc);
      n++;
    end
    chk("drain_done", q.size() == 0, 1'b1);
    tick(acc);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic acc;
    int   len;
    reset_n    = 1'b0;
    i_en       = 1'b1;
    i_flush    = 1'b0;
    bus.s_vld  = 1'b0;
    bus.s_data = '0;
    bus.s_op   = '0;
    bus.s_last = 1'b0;
    bus.o_rdy  = 1'b0;
    rand_rdy   = 1'b0;
    rand_en    = 1'b0;
    gaps       = 1'b0;
    model_clear();

    // Reset values.
    #3;
    chk("rst_outputs", {bus.o_vld, o_err, bus.o_op, bus.o_r0, bus.o_r1, bus.o_r2, bus.o_r3}, '0);
    chk("rst_s_rdy", bus.s_rdy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("s_rdy_before_first_edge", bus.s_rdy, 1'b0);
    @(posedge clk);
    #1 chk("s_rdy_after_first_edge", bus.s_rdy, 1'b1);
    @(negedge clk);

    // Single matrix 01..10, held so its contents can be inspected.
    send_frame(8'h01, 2'b01, 16);
    chk("m1_vld", bus.o_vld, 1'b1);
    chk("m1_r0", bus.o_r0, 32'h04030201);
    chk("m1_r3", bus.o_r3, 32'h100F0E0D);
    chk("m1_op", bus.o_op, 2'b01);
    drain();

    // Back-pressure: two matrices buffered, the third waits without losing an element.
    bus.o_rdy = 1'b0;
    send_frame(8'h20, 2'b10, 16);
    send_frame(8'h40, 2'b11, 16);
    bus.s_vld  = 1'b1;
    bus.s_data = 8'h60;
    bus.s_op   = 2'b00;
    bus.s_last = 1'b0;
    repeat (3) begin
      tick(acc);
      chk("full_blocks_accept", acc, 1'b0);
    end
    bus.o_rdy = 1'b1;
    send_frame(8'h60, 2'b00, 16);
    drain();

    // Short frame then a well-formed one.
    bus.o_rdy = 1'b0;
    send_frame(8'h50, 2'b10, 5);
    tick(acc);
    send_frame(8'hA0, 2'b11, 16);
    chk("after_short_r0", bus.o_r0, 32'hA3A2A1A0);
    drain();

    // Long frame of 20 beats then a well-formed one.
    send_frame(8'hC0, 2'b01, 20);
    send_frame(8'h10, 2'b10, 16);
    drain();

    // Flush with one matrix buffered and another half-filled.
    bus.o_rdy = 1'b0;
    send_frame(8'h30, 2'b01, 16);
    for (int i = 0; i < 8; i++) drive_beat(8'(8'h70 + 8'(i)), 2'b11, 1'b0);
    i_flush    = 1'b1;
    bus.o_rdy  = 1'b1;
    bus.s_vld  = 1'b1;
    bus.s_data = 8'hEE;
    tick(acc);
    i_flush   = 1'b0;
    bus.s_vld = 1'b0;
    chk("flush_o_vld", bus.o_vld, 1'b0);
    bus.o_rdy = 1'b0;
    send_frame(8'h80, 2'b10, 16);
    chk("post_flush_r0", bus.o_r0, 32'h83828180);
    drain();

    // Asynchronous reset mid-frame with a matrix buffered.
    bus.o_rdy = 1'b0;
    send_frame(8'h90, 2'b11, 16);
    for (int i = 0; i < 7; i++) drive_beat(8'(8'hB0 + 8'(i)), 2'b01, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {bus.o_vld, o_err, bus.o_op, bus.o_r0, bus.o_r1, bus.o_r2, bus.o_r3}, '0);
    chk("midrst_s_rdy", bus.s_rdy, 1'b0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("midrst_s_rdy_release", bus.s_rdy, 1'b0);
    @(posedge clk);
    #1 chk("midrst_s_rdy_rise", bus.s_rdy, 1'b1);
    @(negedge clk);
    send_frame(8'hD0, 2'b01, 16);
    chk("post_rst_r0", bus.o_r0, 32'hD3D2D1D0);
    drain();
`ifdef MAPU_ROW_PACKER_STATS_EN
    chk("post_rst_mat_cnt", o_mat_cnt, 16'd1);
`endif

    // Randomized frames with random gaps, back-pressure and input enable.
    rand_rdy = 1'b1;
    rand_en  = 1'b1;
    gaps     = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(1, 24));
      send_random_frame(len);
    end
    rand_rdy = 1'b0;
    rand_en  = 1'b0;
    gaps     = 1'b0;
    i_en     = 1'b1;
    drain();
    chk("final_idle", bus.o_vld, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
